// File: rtl/score_collector_10.sv
// Gathers ten output-layer accumulators, requantizes each to an unsigned 8-bit score
// (ReLU + saturate), and holds the packed 80-bit frame until the argmax stage acks it.
module score_collector_10 #(
    parameter int ACC_W = 20,
    parameter int SHIFT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [ACC_W-1:0] iAcc,
    input  logic                    iValid,
    output logic                    oReady,
    input  logic                    iClear,
    output logic [79:0]             data_out,
    output logic                    oValid,
    input  logic                    iAck,
    output logic                    oSat
);

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] FULL    = 1'b1;

    logic [0:0]              state_reg;
    logic [3:0]              cnt_reg;
    logic                    sat_reg;
    logic [79:0]             data_reg;

    logic signed [ACC_W-1:0] shifted;
    logic                    is_neg;
    logic                    is_big;
    logic [7:0]              score;
    logic                    take;
    logic [9:0]              slot_we;

    assign shifted = iAcc >>> SHIFT;
    assign is_neg  = shifted[ACC_W-1];
    // Anything above bit 7 (excluding the sign) means the value exceeds 255.
    assign is_big  = !is_neg && (|shifted[ACC_W-2:8]);
    assign score   = is_neg ? 8'h00 : (is_big ? 8'hFF : shifted[7:0]);

    assign oReady = (state_reg == COLLECT);
    assign oValid = (state_reg == FULL);
    // A clear in the same cycle wins, so the presented beat is dropped.
    assign take   = iValid && (state_reg == COLLECT) && !iClear;

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_we
            assign slot_we[gi] = take && (cnt_reg == 4'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= COLLECT;
            cnt_reg   <= 4'd0;
            sat_reg   <= 1'b0;
        end else if (iClear) begin
            state_reg <= COLLECT;
            cnt_reg   <= 4'd0;
            sat_reg   <= 1'b0;
        end else begin
            case (state_reg)
                COLLECT: begin
                    if (iValid) begin
                        if (is_big) begin
                            sat_reg <= 1'b1;
                        end
                        if (cnt_reg == 4'd9) begin
                            cnt_reg   <= 4'd0;
                            state_reg <= FULL;
                        end else begin
                            cnt_reg <= cnt_reg + 4'd1;
                        end
                    end
                end
                default: begin
                    if (iAck) begin
                        state_reg <= COLLECT;
                        sat_reg   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Slots are never zeroed by ack or clear; only reset or a new beat changes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= 80'h0;
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (slot_we[i]) begin
                    data_reg[8*i +: 8] <= score;
                end
            end
        end
    end

    assign data_out = data_reg;
    assign oSat     = sat_reg;

endmodule

// File: doc/score_collector_10.md
# score_collector_10

Collects the ten output-layer neuron accumulators of the DNN, one per handshake beat, and requantizes each to an unsigned 8-bit score with ReLU and saturation. It packs them into the 80-bit vector consumed by the downstream `max_in_10` argmax stage and holds that frame stable until the consumer acknowledges it. It sits between the TPU output-layer MAC array and `max_in_10`.

## Interface

Parameters:
- `ACC_W`, default 20: width of the signed accumulator input.
- `SHIFT`, default 8: arithmetic right shift applied before clamping; legal range 0..ACC_W-1.

Ports:
- `clk`  in  1  system clock; the only clock. All state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `iAcc`  in  ACC_W  signed accumulator for the current neuron.
- `iValid`  in  1  `iAcc` is valid this cycle.
- `oReady`  out  1  block can accept a beat this cycle.
- `iClear`  in  1  synchronous frame abort.
- `data_out`  out  80  packed scores; score k occupies bits [8k+7:8k]; connects to `max_in_10.data_in`.
- `oValid`  out  1  `data_out` holds a complete frame.
- `iAck`  in  1  consumer has taken the frame.
- `oSat`  out  1  sticky per frame: at least one score of the frame was clamped to 255.

## Operation

- Two states:
  - COLLECT: beat counter `cnt` runs 0..9.
  - FULL: frame complete and held.
- Requantize: `s = iAcc >>> SHIFT` (arithmetic shift).
  - s < 0: score = 0 (ReLU). This does not set `oSat`.
  - s > 255: score = 255, and `oSat` is set.
  - otherwise: score = s[7:0].
- Beat accepted when `iValid & oReady` at a rising edge. The score is written to slot `cnt`, then `cnt` increments.
- Accepting the beat with `cnt`=9 transitions to FULL and sets `cnt` to 0.
- COLLECT: `oReady`=1, `oValid`=0.
- FULL: `oReady`=0, `oValid`=1. `data_out` and `oSat` are frozen.
- FULL with `iAck`=1: next state COLLECT, `oSat` clears, `oValid` drops.
- `data_out` slots are not zeroed on ack. They keep the old frame until each slot is overwritten.
- `iClear`=1 in any state:
  - next state COLLECT, `cnt`=0, `oSat`=0;
  - slots are unchanged;
  - `iClear` has priority over a beat or ack in the same cycle, so that beat is discarded.
- `iValid` while FULL is ignored and not stored. The upstream stage must hold it until `oReady` is high.
- `iAck` while in COLLECT is ignored.

## Timing

- Reset values: state COLLECT, `cnt`=0, `data_out`=80'h0, `oValid`=0, `oSat`=0. `oReady`=1 once `rst_n` is high.
- `oReady` and `oValid` are decoded from state only. They have no combinational path from any input.
- Latency:
  - 10th accepted beat at edge N gives `oValid`=1 in the cycle after N.
  - Minimum frame period is 11 cycles: 10 beats plus 1 ack cycle. This applies when `iAck` is tied high.
- Ack at edge M gives `oReady`=1 in the cycle after M. A beat presented in the same cycle as the ack is not accepted, because `oReady` was 0.
- `data_out` is registered. The slot for a beat accepted at edge N is updated right after N.
- Reset mid-frame or in FULL: immediate return to the reset values. Any partial frame is lost.
- Back-to-back `iValid` in COLLECT is accepted every cycle with no bubbles.

## Test plan

- Reset, then 10 beats with `iAcc` = k·256 for k=0..9 (SHIFT=8):
  - `data_out` = {8'd9,8'd8,…,8'd0};
  - `oValid` rises exactly 1 cycle after the 10th beat;
  - `oSat`=0;
  - the attached `max_in_10` reports max 9, index 9.
- Clamp: beats `iAcc` = −300, 0, 20'h7FFFF, 255·256, and six of 0:
  - slot0=0, slot2=255, slot3=255;
  - `oSat`=1.
- Hold: after FULL, keep `iValid`=1 with new data for 5 cycles, then pulse `iAck`:
  - `data_out` is unchanged during the hold;
  - `oReady` is high in the cycle after the ack;
  - the next frame's first beat lands in slot 0.
- Abort: 4 beats, then `iClear` together with `iValid`, then 10 beats:
  - the frame completes only after the 10 new beats;
  - the beat presented with `iClear` is discarded.
- Async reset mid-frame (after 6 beats), asserting `rst_n` low away from a clock edge:
  - outputs go to the reset values immediately, with no clock edge needed;
  - a full 10-beat frame is required afterwards.
- Throughput: 3 consecutive frames with `iValid` and `iAck` held high:
  - `oValid` pulses every 11 cycles;
  - each frame's `data_out` is correct.
